// File: rtl/cpu_pkg.sv
// Shared types for the 16-bit pipelined core: result select, register/word types
// and the writeback debug-port FSM states.
package cpu_pkg;

  localparam int unsigned WORD_W  = 16;
  localparam int unsigned NUM_REG = 16;
  localparam int unsigned REG_AW  = $clog2(NUM_REG);

  typedef logic [REG_AW-1:0] reg_addr_t;
  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    RES_ALU  = 2'b00,
    RES_MEM  = 2'b01,
    RES_PC2  = 2'b10,
    RES_RSVD = 2'b11
  } result_src_t;

  typedef enum logic [1:0] {
    DBG_IDLE    = 2'b00,
    DBG_CAPTURE = 2'b01,
    DBG_ACK     = 2'b10
  } dbg_state_t;

endpackage

// File: rtl/writeback_stage_if.sv
// Debug read handshake between the test harness (master) and the writeback stage (slave).
interface writeback_stage_if #(
  parameter int DATA_W = 16,
  parameter int AW     = 4
);
  logic              dbg_req;
  logic [AW-1:0]     dbg_addr;
  logic              dbg_ack;
  logic [DATA_W-1:0] dbg_data;
  logic              dbg_busy;

  modport master (output dbg_req, dbg_addr, input dbg_ack, dbg_data, dbg_busy);
  modport slave  (input dbg_req, dbg_addr, output dbg_ack, dbg_data, dbg_busy);
endinterface

// File: rtl/regfile_2r1w.sv
// Architectural register file: one write port, two decode read ports plus a debug
// tap, all reads write-first bypassed against the commit in the same cycle.
module regfile_2r1w #(
  parameter int DATA_W  = 16,
  parameter int NREGS   = 16,
  parameter int R0_ZERO = 1,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     ra1,
  input  logic [AW-1:0]     ra2,
  input  logic [AW-1:0]     ra3,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  output logic [DATA_W-1:0] rd3
);
  localparam bit R0Z = (R0_ZERO != 0);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic              wr_en;

  // Writes to r0 are dropped here, so the bypass below never forwards them either.
  assign wr_en = we && !(R0Z && (waddr == '0));

  always_comb begin
    regs_d = regs_q;
    if (wr_en) regs_d[waddr] = wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  assign rd1 = (R0Z && ra1 == '0)     ? '0    :
               (wr_en && ra1 == waddr) ? wdata : regs_q[ra1];
  assign rd2 = (R0Z && ra2 == '0)     ? '0    :
               (wr_en && ra2 == waddr) ? wdata : regs_q[ra2];
  assign rd3 = (R0Z && ra3 == '0)     ? '0    :
               (wr_en && ra3 == waddr) ? wdata : regs_q[ra3];

endmodule

// File: rtl/writeback_stage.sv
// MEM/WB consumer: result mux, register-file commit, decode reads and debug read port.
// Optional retire/load counters are built when WB_PERF_CNT_EN is defined.
module writeback_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int NREGS   = 16,
  parameter int R0_ZERO = 1,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              regWriteW,
  input  logic [1:0]        resultSrcW,
  input  logic [DATA_W-1:0] aluResW,
  input  logic [DATA_W-1:0] readDataW,
  input  logic [DATA_W-1:0] PCPlus2W,
  input  logic [AW-1:0]     RdW,
  input  logic [AW-1:0]     Ra1D,
  input  logic [AW-1:0]     Ra2D,
  output logic [DATA_W-1:0] Rd1D,
  output logic [DATA_W-1:0] Rd2D,
  output logic [DATA_W-1:0] ResultW,
  writeback_stage_if.slave  dbg
`ifdef WB_PERF_CNT_EN
  ,
  output logic [31:0]       retire_cnt,
  output logic [31:0]       load_cnt
`endif
);

  always_comb begin
    ResultW = '0;
    case (result_src_t'(resultSrcW))
      RES_ALU: ResultW = aluResW;
      RES_MEM: ResultW = readDataW;
      RES_PC2: ResultW = PCPlus2W;
      default: ResultW = '0;
    endcase
  end

  dbg_state_t        state_q, state_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] dbg_rd;

  regfile_2r1w #(
    .DATA_W  (DATA_W),
    .NREGS   (NREGS),
    .R0_ZERO (R0_ZERO)
  ) u_regfile (
    .clk   (clk),
    .rst_n (rst),
    .we    (regWriteW),
    .waddr (RdW),
    .wdata (ResultW),
    .ra1   (Ra1D),
    .ra2   (Ra2D),
    .ra3   (addr_q),
    .rd1   (Rd1D),
    .rd2   (Rd2D),
    .rd3   (dbg_rd)
  );

  // Requests are only looked at in IDLE, so anything arriving while busy is dropped.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    case (state_q)
      DBG_IDLE: begin
        if (dbg.dbg_req) begin
          addr_d  = dbg.dbg_addr;
          state_d = DBG_CAPTURE;
        end
      end
      DBG_CAPTURE: begin
        data_d  = dbg_rd;
        state_d = DBG_ACK;
      end
      DBG_ACK: state_d = DBG_IDLE;
      default: state_d = DBG_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= DBG_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign dbg.dbg_ack  = (state_q == DBG_ACK);
  assign dbg.dbg_busy = (state_q != DBG_IDLE);
  assign dbg.dbg_data = data_q;

`ifdef WB_PERF_CNT_EN
  logic [31:0] retire_q, retire_d;
  logic [31:0] load_q, load_d;

  // Retires count every commit attempt, including writes discarded at r0.
  always_comb begin
    retire_d = retire_q;
    load_d   = load_q;
    if (regWriteW) begin
      retire_d = retire_q + 32'd1;
      if (result_src_t'(resultSrcW) == RES_MEM) load_d = load_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      retire_q <= '0;
      load_q   <= '0;
    end else begin
      retire_q <= retire_d;
      load_q   <= load_d;
    end
  end

  assign retire_cnt = retire_q;
  assign load_cnt   = load_q;
`endif

endmodule
